ndiv_seq: RTL
=============

Name: ndiv_seq

Overview:
- Sequential radix-2 restoring integer divider with quotient and remainder outputs, parametrised in width N.
- Supports unsigned and signed (two's-complement) division, selected per operation.
- Uses a valid/ready handshake on both the input and output sides.
- Replaces the earlier combinational divider attempt. It is the arithmetic datapath divider used behind the multiplier (nmul) in the same block group.

Parameters:
- N, 32, operand/quotient/remainder width in bits (N >= 4).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand request valid
- in_ready  output  1  divider can accept an operation
- is_signed  input  1  1 = signed division, 0 = unsigned; sampled with the operands
- a  input  N  dividend
- b  input  N  divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- quot  output  N  quotient
- rem  output  N  remainder
- dz  output  1  divide-by-zero flag, qualified by out_valid
- ovf  output  1  signed overflow flag (MIN / -1), qualified by out_valid

Behaviour:
- Reset values: state IDLE, in_ready=1, out_valid=0, quot=0, rem=0, dz=0, ovf=0. All internal registers are cleared.
- Reset is asynchronous. Asserting it mid-operation aborts the operation immediately; no result is ever presented for it.
- States and transitions:
  - IDLE -> BUSY on in_valid & in_ready, normal case.
  - IDLE -> DONE on in_valid & in_ready, special case (b==0, or signed MIN/-1).
  - BUSY -> DONE after exactly N iteration cycles.
  - DONE -> IDLE on out_valid & out_ready.
- in_ready = (state==IDLE). out_valid = (state==DONE). There is no overlap between operations.
- Accept edge: latch is_signed.
  - Unsigned: working magnitudes are a and b.
  - Signed: working magnitudes are |a| and |b|. Also record sign_q = a[N-1]^b[N-1] and sign_r = a[N-1].
  - Clear the partial remainder (N+1 bits) and the iteration counter (clog2(N)+1 bits).
- BUSY, one step per clock:
  - Shift {partial_rem, dividend} left by 1.
  - Trial subtract the divisor from the N+1-bit partial remainder.
  - If the result is non-negative, keep the difference and set the quotient LSB to 1; otherwise restore and set it to 0.
  - Counter increments; at count N-1 the state goes to DONE.
- Final step: apply sign fix-up (signed mode only).
  - Negate the quotient if sign_q.
  - Negate the remainder if sign_r.
  - Truncate toward zero; the remainder takes the sign of the dividend.
  - Register the results in quot/rem.
- Latency: normal operations have out_valid=1 in the cycle following the Nth clock edge after the accept edge. Special cases have out_valid=1 in the cycle right after the accept edge.
- Divide-by-zero (b==0, either mode): quot = all ones, rem = a (unmodified), dz=1, ovf=0.
- Signed overflow (is_signed, a==2^(N-1) bit pattern, b==all ones): quot = a, rem = 0, ovf=1, dz=0.
- Unsigned mode never sets ovf. The dz check takes priority over the ovf check.
- Results hold stable while out_valid=1 and out_ready=0 (backpressure of unbounded length).
- Inputs a/b/is_signed are don't-care outside the accept edge; changing them during BUSY has no effect.
- in_valid asserted during BUSY/DONE is ignored (in_ready=0). The request must be held by the source until accepted.
- Simultaneous handshake: a DONE->IDLE handshake and a new in_valid in the same cycle do not accept the new request. It is accepted at the next edge, when in_ready=1.

Test Plan:
- N=32, unsigned, a=100, b=7 -> quot=14, rem=2, dz=0, ovf=0; out_valid exactly 32 cycles after accept.
- N=8, signed, a=-7 (0xF9), b=2 -> quot=-3 (0xFD), rem=-1 (0xFF). Then a=7, b=-2 -> quot=0xFD, rem=0x01.
- N=8, b=0, a=0x5A, both modes -> quot=0xFF, rem=0x5A, dz=1; out_valid one cycle after accept.
- N=8, signed, a=0x80, b=0xFF -> quot=0x80, rem=0, ovf=1. The same operands unsigned -> quot=0, rem=0x80, ovf=0.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid, quot and rem stable, in_ready=0. Then pulse out_ready -> IDLE, and the next request is accepted one cycle later.
- Reset mid-operation: assert rst at iteration 5 of a=1000, b=3 -> outputs return to reset values asynchronously; no stale out_valid. A fresh 1000/3 then yields quot=333, rem=1.

Source files
------------

// File: rtl/ndiv_seq_if.sv
// Operand request / result bundle for the sequential divider.
// Latency: none, wires only.
// Backpressure: valid/ready on both the request side and the result side.
interface ndiv_seq_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic         is_signed;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quot;
    logic [N-1:0] rem;
    logic         dz;
    logic         ovf;

    // Requester side: issues operands, consumes results.
    modport master (
        output in_valid, is_signed, a, b, out_ready,
        input  in_ready, out_valid, quot, rem, dz, ovf
    );

    // Divider side.
    modport slave (
        input  in_valid, is_signed, a, b, out_ready,
        output in_ready, out_valid, quot, rem, dz, ovf
    );
endinterface

// File: rtl/ndiv_seq.sv
// Radix-2 restoring divider, unsigned or signed per operation, quotient and remainder.
// Latency: N cycles after accept for normal ops, 1 cycle for divide-by-zero and MIN/-1.
// Backpressure: one op in flight; result held in DONE until out_ready, in_ready only in IDLE.
module ndiv_seq #(
    parameter int N = 32
) (
    input  logic       clk,
    input  logic       rst,
    ndiv_seq_if.slave  bus
);
    localparam int            CW      = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST    = CW'(N - 1);
    localparam logic [N-1:0]  MIN_VAL = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;

    // Operation context latched at accept
    logic          sgn;
    logic          sign_q;
    logic          sign_r;
    logic [N-1:0]  prem;      // partial remainder (always below the divisor)
    logic [N-1:0]  dvd;       // dividend shifting out, quotient shifting in
    logic [N-1:0]  dvs;       // divisor magnitude
    logic [CW-1:0] cnt;

    // Result registers presented while DONE
    logic [N-1:0]  quot_r;
    logic [N-1:0]  rem_r;
    logic          dz_r;
    logic          ovf_r;

    logic          accept;
    logic          last_step;
    logic [N-1:0]  mag_a;
    logic [N-1:0]  mag_b;
    logic          is_dz;
    logic          is_ovf;
    logic          special;
    logic [N:0]    shifted;
    logic [N:0]    diff;
    logic [N-1:0]  prem_nx;
    logic [N-1:0]  dvd_nx;
    logic [N-1:0]  q_fix;
    logic [N-1:0]  r_fix;

    // Operand conditioning: magnitudes and the two short-circuit cases
    always_comb begin
        mag_a   = (bus.is_signed && bus.a[N-1]) ? -bus.a : bus.a;
        mag_b   = (bus.is_signed && bus.b[N-1]) ? -bus.b : bus.b;
        is_dz   = (bus.b == '0);
        is_ovf  = bus.is_signed && (bus.a == MIN_VAL) && (bus.b == '1);
        special = is_dz || is_ovf;
    end

    // One restoring iteration plus the sign fix-up applied on the final step
    always_comb begin
        // The N+1-bit trial covers the bit shifted out of the partial remainder
        shifted = {prem, dvd[N-1]};
        diff    = shifted - {1'b0, dvs};
        prem_nx = diff[N] ? shifted[N-1:0] : diff[N-1:0];
        dvd_nx  = {dvd[N-2:0], ~diff[N]};
        q_fix   = (sgn && sign_q) ? -dvd_nx : dvd_nx;
        r_fix   = (sgn && sign_r) ? -prem_nx : prem_nx;
    end

    // Control state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and step qualifiers
    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        last_step = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    accept   = 1'b1;
                    state_nx = special ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt == LAST) begin
                    last_step = 1'b1;
                    state_nx  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: latch on accept, iterate while BUSY, capture results on the last step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sgn    <= 1'b0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            prem   <= '0;
            dvd    <= '0;
            dvs    <= '0;
            cnt    <= '0;
            quot_r <= '0;
            rem_r  <= '0;
            dz_r   <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (accept) begin
            sgn    <= bus.is_signed;
            sign_q <= bus.is_signed & (bus.a[N-1] ^ bus.b[N-1]);
            sign_r <= bus.is_signed & bus.a[N-1];
            prem   <= '0;
            dvd    <= mag_a;
            dvs    <= mag_b;
            cnt    <= '0;
            // Zero divisor wins over MIN/-1
            if (is_dz) begin
                quot_r <= '1;
                rem_r  <= bus.a;
                dz_r   <= 1'b1;
                ovf_r  <= 1'b0;
            end else if (is_ovf) begin
                quot_r <= bus.a;
                rem_r  <= '0;
                dz_r   <= 1'b0;
                ovf_r  <= 1'b1;
            end else begin
                dz_r   <= 1'b0;
                ovf_r  <= 1'b0;
            end
        end else if (state == BUSY) begin
            prem <= prem_nx;
            dvd  <= dvd_nx;
            cnt  <= cnt + CW'(1);
            if (last_step) begin
                quot_r <= q_fix;
                rem_r  <= r_fix;
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.quot      = quot_r;
    assign bus.rem       = rem_r;
    assign bus.dz        = dz_r;
    assign bus.ovf       = ovf_r;
endmodule
